// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter merging three cache-side Wishbone masters onto one inner bus.
// The grant is held for the owner's whole cyc. A stall watchdog and a grant-disable gate are included.
module wb_master_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_disable,
  input  logic [2:0]          m_cyc,
  input  logic [2:0]          m_stb,
  input  logic [2:0]          m_we,
  input  logic [3*ADDR_W-1:0] m_adr,
  input  logic [3*DATA_W-1:0] m_dat_w,
  input  logic [3*SEL_W-1:0]  m_sel,
  input  logic [2:0]          m_burst4,
  input  logic [2:0]          m_burst8,
  output logic [DATA_W-1:0]   m_dat_r,
  output logic [2:0]          m_ack,
  output logic [2:0]          m_err,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [ADDR_W-1:0]   o_wb_adr,
  output logic [DATA_W-1:0]   o_wb_dat,
  output logic [SEL_W-1:0]    o_wb_sel,
  output logic                o_wb_4_burst,
  output logic                o_wb_8_burst,
  input  logic [DATA_W-1:0]   i_wb_dat,
  input  logic                i_wb_ack,
  input  logic                i_wb_err,
  output logic [1:0]          o_owner
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic              owned, timeout;
  logic              sel_cyc, sel_stb, sel_we, sel_b4, sel_b8;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_dat;
  logic [SEL_W-1:0]  sel_sel;
  logic              pick_vld;
  logic [1:0]        pick, cand;

  function automatic logic [1:0] rr_next(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic req_of(input logic [2:0] c, input logic [1:0] i);
    case (i)
      2'd0:    return c[0];
      2'd1:    return c[1];
      default: return c[2];
    endcase
  endfunction

  // Owner mux: owner_q is 3 outside OWN, so nothing matches and everything stays 0.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_b4  = 1'b0;
    sel_b8  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    for (int k = 0; k < 3; k++) begin
      if (owner_q == 2'(k)) begin
        sel_cyc = m_cyc[k];
        sel_stb = m_stb[k];
        sel_we  = m_we[k];
        sel_b4  = m_burst4[k];
        sel_b8  = m_burst8[k];
        sel_adr = m_adr[k*ADDR_W +: ADDR_W];
        sel_dat = m_dat_w[k*DATA_W +: DATA_W];
        sel_sel = m_sel[k*SEL_W +: SEL_W];
      end
    end
  end

  assign owned   = (state_q == OWN) && !i_rst;
  assign timeout = (TIMEOUT != 0) && owned && sel_stb && !i_wb_ack && !i_wb_err &&
                   (wdog_q == WD_FIRE);

  assign o_wb_cyc     = owned && sel_cyc && !timeout;
  assign o_wb_stb     = owned && sel_stb && !timeout;
  assign o_wb_we      = owned && sel_we;
  assign o_wb_4_burst = owned && sel_b4;
  assign o_wb_8_burst = owned && sel_b8;
  assign o_wb_adr     = owned ? sel_adr : '0;
  assign o_wb_dat     = owned ? sel_dat : '0;
  assign o_wb_sel     = owned ? sel_sel : '0;
  assign o_owner      = owned ? owner_q : 2'd3;
  assign m_dat_r      = i_wb_dat;

  always_comb begin
    m_ack = 3'b000;
    m_err = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (owned && owner_q == 2'(k)) begin
        m_ack[k] = i_wb_ack;
        m_err[k] = i_wb_err | timeout;
      end
    end
  end

  // Round-robin search starting just after the last granted master.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 2'd0;
    cand     = rr_next(last_q);
    for (int j = 0; j < 3; j++) begin
      if (!pick_vld && req_of(m_cyc, cand)) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (!i_disable && pick_vld) begin
          state_d = OWN;
          owner_d = pick;
          last_d  = pick;
        end
      end
      OWN: begin
        if (!sel_cyc || timeout) begin
          state_d = GAP;
          owner_d = 2'd3;
          wdog_d  = '0;
        end else if (i_wb_ack || i_wb_err) begin
          wdog_d = '0;
        end else if (sel_stb && wdog_q != WD_MAX) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        owner_d = 2'd3;
        wdog_d  = '0;
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'd3;
        wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= 2'd3;
      last_q  <= 2'd2;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: per-cycle vector table plus a hand-written reset-mid-burst sequence.
module tb_wb_master_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 2;

  logic                i_clk, i_rst, i_disable;
  logic [2:0]          m_cyc, m_stb, m_we, m_burst4, m_burst8;
  logic [3*ADDR_W-1:0] m_adr;
  logic [3*DATA_W-1:0] m_dat_w;
  logic [3*SEL_W-1:0]  m_sel;
  logic [DATA_W-1:0]   m_dat_r;
  logic [2:0]          m_ack, m_err;
  logic                o_wb_cyc, o_wb_stb, o_wb_we, o_wb_4_burst, o_wb_8_burst;
  logic [ADDR_W-1:0]   o_wb_adr;
  logic [DATA_W-1:0]   o_wb_dat;
  logic [SEL_W-1:0]    o_wb_sel;
  logic [DATA_W-1:0]   i_wb_dat;
  logic                i_wb_ack, i_wb_err;
  logic [1:0]          o_owner;

  wb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_disable(i_disable),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_sel(m_sel), .m_burst4(m_burst4), .m_burst8(m_burst8),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
    .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_4_burst(o_wb_4_burst),
    .o_wb_8_burst(o_wb_8_burst), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack),
    .i_wb_err(i_wb_err), .o_owner(o_owner)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       rst_b;
    logic [2:0] cyc;
    logic [2:0] stb;
    logic       ack;
    logic       err;
    logic       dis;
    logic       e_cyc;
    logic       e_stb;
    logic [1:0] e_own;
    logic [2:0] e_ack;
    logic [2:0] e_err;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  logic [ADDR_W-1:0] adr_c [3];
  logic [DATA_W-1:0] dat_c [3];
  logic [SEL_W-1:0]  sel_c [3];

  function automatic vec_t mk(input logic rb, input logic [2:0] c, input logic [2:0] s,
                              input logic a, input logic e, input logic d,
                              input logic ec, input logic es, input logic [1:0] eo,
                              input logic [2:0] ea, input logic [2:0] ee);
    vec_t v;
    v.rst_b = rb; v.cyc = c; v.stb = s; v.ack = a; v.err = e; v.dis = d;
    v.e_cyc = ec; v.e_stb = es; v.e_own = eo; v.e_ack = ea; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Expected routed bus fields for a given owner (3 = nothing routed), plus read data passthrough.
  function automatic logic [63:0] exp_data(input logic [1:0] own);
    logic [63:0] r;
    r = '0;
    if (own != 2'd3)
      r = {3'b000, adr_c[own], dat_c[own], sel_c[own], m_we[own], m_burst4[own], m_burst8[own], i_wb_dat};
    else
      r = {3'b000, 24'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, i_wb_dat};
    return r;
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    m_cyc = 3'b000; m_stb = 3'b000;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_disable = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    adr_c[0] = 24'h0A0A0A; adr_c[1] = 24'h1B1B1B; adr_c[2] = 24'h2C2C2C;
    dat_c[0] = 16'hA000;   dat_c[1] = 16'hB111;   dat_c[2] = 16'hC222;
    sel_c[0] = 2'b01;      sel_c[1] = 2'b10;      sel_c[2] = 2'b11;
    m_adr    = {adr_c[2], adr_c[1], adr_c[0]};
    m_dat_w  = {dat_c[2], dat_c[1], dat_c[0]};
    m_sel    = {sel_c[2], sel_c[1], sel_c[0]};
    m_we     = 3'b101;
    m_burst4 = 3'b100;
    m_burst8 = 3'b010;
    i_wb_dat = 16'hBEEF;
    i_rst = 1'b1; i_disable = 1'b0;
    m_cyc = 3'b000; m_stb = 3'b000; i_wb_ack = 1'b0; i_wb_err = 1'b0;

    // m0 single read from reset
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 0, 1, 1, 2'd0, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b001, 3'b001, 1, 0, 0, 1, 1, 2'd0, 3'b001, 3'b000));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 2'd0, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    // all three requesting: m0, m1, m2, m0 with gaps; ack/err ignored in GAP
    tbl.push_back(mk(1, 3'b111, 3'b111, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b111, 3'b111, 1, 0, 0, 1, 1, 2'd0, 3'b001, 3'b000));
    tbl.push_back(mk(0, 3'b110, 3'b110, 0, 0, 0, 0, 0, 2'd0, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b110, 3'b110, 1, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b110, 3'b110, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b110, 3'b110, 1, 0, 0, 1, 1, 2'd1, 3'b010, 3'b000));
    tbl.push_back(mk(0, 3'b101, 3'b101, 0, 0, 0, 0, 0, 2'd1, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b101, 3'b101, 0, 1, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b101, 3'b101, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b101, 3'b101, 1, 0, 0, 1, 1, 2'd2, 3'b100, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd2, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 1, 0, 0, 1, 1, 2'd0, 3'b001, 3'b000));
    tbl.push_back(mk(0, 3'b010, 3'b010, 0, 0, 0, 0, 0, 2'd0, 3'b000, 3'b000));
    // m2 4-beat burst while m0/m1 wait
    tbl.push_back(mk(1, 3'b100, 3'b100, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b111, 3'b111, 0, 0, 0, 1, 1, 2'd2, 3'b000, 3'b000));
    repeat (4) tbl.push_back(mk(0, 3'b111, 3'b111, 1, 0, 0, 1, 1, 2'd2, 3'b100, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd2, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 1, 1, 2'd0, 3'b000, 3'b000));
    // watchdog (TIMEOUT=8): error on the 8th stalled cycle, then m1 granted
    tbl.push_back(mk(1, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    repeat (7) tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 1, 1, 2'd0, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd0, 3'b000, 3'b001));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 0, 1, 1, 2'd1, 3'b000, 3'b000));
    // disable during m1 cycle, m0 waiting; simultaneous ack+err forwarded
    tbl.push_back(mk(1, 3'b010, 3'b010, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 0, 0, 1, 1, 1, 2'd1, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b011, 3'b011, 1, 1, 1, 1, 1, 2'd1, 3'b010, 3'b010));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 1, 0, 0, 2'd1, 3'b000, 3'b000));
    repeat (3) tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 1, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 0, 0, 0, 2'd3, 3'b000, 3'b000));
    tbl.push_back(mk(0, 3'b001, 3'b001, 0, 0, 0, 1, 1, 2'd0, 3'b000, 3'b000));

    @(negedge i_clk);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_b) do_reset();
      m_cyc     = tbl[i].cyc;
      m_stb     = tbl[i].stb;
      i_wb_ack  = tbl[i].ack;
      i_wb_err  = tbl[i].err;
      i_disable = tbl[i].dis;
      #2;
      check($sformatf("row%0d_ctl", i),
            {51'd0, o_wb_cyc, o_wb_stb, o_owner, m_ack, m_err},
            {51'd0, tbl[i].e_cyc, tbl[i].e_stb, tbl[i].e_own, tbl[i].e_ack, tbl[i].e_err});
      check($sformatf("row%0d_data", i),
            {3'b000, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_4_burst, o_wb_8_burst, m_dat_r},
            exp_data(tbl[i].e_own));
      @(posedge i_clk);
      @(negedge i_clk);
    end

    // reset asserted mid-burst while m1 owns and the slave is acking
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010;
    @(posedge i_clk);
    @(negedge i_clk);
    m_cyc = 3'b011; m_stb = 3'b011; i_wb_ack = 1'b1; i_wb_dat = 16'h1234;
    #2;
    check("rst_pre_owner", 64'(o_owner), 64'(2'd1));
    check("rst_pre_ack", 64'(m_ack), 64'(3'b010));
    check("rst_pre_dat_r", 64'(m_dat_r), 64'(16'h1234));
    @(posedge i_clk);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("rst_async_cyc", 64'({o_wb_cyc, o_wb_stb}), 64'(2'b00));
    check("rst_async_ack", 64'({m_ack, m_err}), 64'(6'b000000));
    check("rst_async_owner", 64'(o_owner), 64'(2'd3));
    @(negedge i_clk);
    i_rst = 1'b0; i_wb_ack = 1'b0;
    #2;
    check("rst_post_idle", 64'(o_owner), 64'(2'd3));
    @(posedge i_clk);
    @(negedge i_clk);
    #2;
    check("rst_post_m0_wins", 64'(o_owner), 64'(2'd0));
    check("rst_post_adr", 64'(o_wb_adr), 64'(adr_c[0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
